// File: rtl/mctrl_pkg.sv
// mctrl_pkg: opcodes, ALU codes, FSM states and mux encodings shared by the multi-cycle controller and the ALU.
package mctrl_pkg;
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_OR   = 6'b010011;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLTI = 6'b011100;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;
    localparam logic [5:0] OP_BLTZ = 6'b110010;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_RS  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;
    localparam logic [1:0] RD_31 = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;
    typedef enum logic [3:0] {
        S_IF, S_ID, S_EXE_AL, S_WB_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_LD, S_HALT
    } state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps an opcode to the ALU operation, operand selects and immediate extension mode.
module alu_op_decode import mctrl_pkg::*; (
    input  logic [5:0] opcode,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       ext_sel
);
    always_comb begin
        alu_op = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel = 1'b0;
        case (opcode)
            OP_SUB:              alu_op = ALU_SUB;
            OP_ADDIU:            {alu_src_b, ext_sel} = 2'b11;
            OP_ANDI:             {alu_op, alu_src_b} = {ALU_AND, 1'b1};
            OP_AND:              alu_op = ALU_AND;
            OP_ORI:              {alu_op, alu_src_b} = {ALU_OR, 1'b1};
            OP_OR:               alu_op = ALU_OR;
            OP_SLL:              {alu_op, alu_src_a} = {ALU_SLL, 1'b1};
            OP_SLTI:             {alu_op, alu_src_b, ext_sel} = {ALU_SLT, 2'b11};
            OP_SW, OP_LW:        {alu_src_b, ext_sel} = 2'b11;
            OP_BEQ, OP_BNE:      {alu_op, ext_sel} = {ALU_SUB, 1'b1};
            OP_BLTZ:             {alu_op, ext_sel} = {ALU_SLT, 1'b1};
            default: ;
        endcase
    end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: IF/ID/EXE/MEM/WB sequencer driving datapath enables for the MIPS-subset CPU.
// Define MCTRL_LINK_JUMP_EN to decode jr/jal; without it those opcodes are illegal and halt.
module multi_cycle_ctrl import mctrl_pkg::*; #(
    parameter logic [5:0] HALT_OPC = 6'b111111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic       pc_wre,
    output logic       ir_wre,
    output logic       reg_wre,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] reg_dst,
    output logic       wr_reg_src,
    output logic       db_data_src,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ext_sel,
    output logic [1:0] pc_src,
    output logic       halted
);
    state_t state;
    logic [2:0] d_alu_op;
    logic d_src_a, d_src_b, d_ext;
    logic is_jr, is_jal, is_jmp, is_br, is_ls, is_al, taken;

    alu_op_decode u_dec (
        .opcode(opcode),
        .alu_op(d_alu_op),
        .alu_src_a(d_src_a),
        .alu_src_b(d_src_b),
        .ext_sel(d_ext)
    );

`ifdef MCTRL_LINK_JUMP_EN
    assign is_jr  = opcode == OP_JR;
    assign is_jal = opcode == OP_JAL;
`else
    assign is_jr  = 1'b0;
    assign is_jal = 1'b0;
`endif
    assign is_jmp = opcode != HALT_OPC && (opcode == OP_J || is_jr || is_jal);
    assign is_br  = opcode inside {OP_BEQ, OP_BNE, OP_BLTZ};
    assign is_ls  = opcode inside {OP_SW, OP_LW};
    assign is_al  = opcode inside {OP_ADD, OP_SUB, OP_ADDIU, OP_ANDI, OP_AND, OP_ORI, OP_OR, OP_SLL, OP_SLTI};
    assign taken  = opcode == OP_BEQ ? zero : opcode == OP_BNE ? !zero : sign;

    always_ff @(posedge clk)
        if (!rst_n) state <= S_IF;
        else case (state)
            S_IF:     state <= S_ID;
            S_ID:     state <= opcode == HALT_OPC ? S_HALT : is_jmp ? S_IF : is_br ? S_EXE_BR :
                               is_ls ? S_EXE_LS : is_al ? S_EXE_AL : S_HALT;
            S_EXE_AL: state <= S_WB_AL;
            S_EXE_LS: state <= S_MEM;
            S_MEM:    state <= opcode == OP_LW ? S_WB_LD : S_IF;
            S_HALT:   state <= S_HALT;
            default:  state <= S_IF;
        endcase

    always_comb begin
        {pc_wre, ir_wre, reg_wre, wr_reg_src, db_data_src, mem_rd, mem_wr, halted} = '0;
        pc_src = PC_SEQ;
        reg_dst = RD_RT;
        {alu_op, alu_src_a, alu_src_b, ext_sel} = '0;
        // ALU controls follow the opcode from ID on, so they stay steady across EXE and its successor
        if (state != S_IF && state != S_HALT) {alu_op, alu_src_a, alu_src_b, ext_sel} = {d_alu_op, d_src_a, d_src_b, d_ext};
        case (state)
            S_IF:     ir_wre = 1'b1;
            S_ID: begin
                pc_wre = is_jmp;
                pc_src = is_jmp ? (is_jr ? PC_RS : PC_JMP) : PC_SEQ;
                reg_wre = is_jmp && is_jal;
                reg_dst = is_jmp && is_jal ? RD_31 : RD_RT;
            end
            S_WB_AL: begin
                {reg_wre, wr_reg_src, pc_wre} = 3'b111;
                reg_dst = d_src_b ? RD_RT : RD_RD;
            end
            S_EXE_BR: {pc_wre, pc_src} = {1'b1, taken ? PC_BR : PC_SEQ};
            S_MEM: begin
                mem_rd = opcode == OP_LW;
                mem_wr = opcode == OP_SW;
                pc_wre = opcode != OP_LW;
            end
            S_WB_LD:  {reg_wre, db_data_src, wr_reg_src, pc_wre} = 4'b1111;
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            {pc_wre, ir_wre, reg_wre, wr_reg_src, db_data_src, mem_rd, mem_wr, halted} = '0;
            {alu_op, alu_src_a, alu_src_b, ext_sel, pc_src, reg_dst} = '0;
        end
    end
endmodule
